imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface: receives a program as a byte stream
//  (valid/ready), packs little-endian 32-bit words and writes them into instruction memory.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader_byte_packer.sv | 63 ++++++
 rtl/imem_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_t     : loader FSM encoding (LD_CSUM is always declared but is
//                        only reachable when LOADER_CSUM_EN is defined)
//   LOADER_COUNT_BYTES : length of the little-endian word-count header
//   PACK_CNT_W         : width of the byte packer's byte counter
//   is_loading()       : true in the states that accept stream bytes
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   typedef enum logic [2:0] {
      LD_LEN,
      LD_DATA,
      LD_CSUM,
      LD_DONE,
      LD_ERROR
   } loader_state_t;

   localparam int LOADER_COUNT_BYTES = 4;
   localparam int PACK_CNT_W         = 8;

   function automatic logic is_loading(input loader_state_t s);
      return (s == LD_LEN) || (s == LD_DATA) || (s == LD_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's control pulse, byte stream and imem write port.
//   start                    : 1-cycle re-arm pulse from DONE/ERROR
//   in_valid/in_data/in_ready: byte stream. A byte moves on a rising clock edge
//                              where in_valid and in_ready are both high; the
//                              source holds in_data stable while in_valid is
//                              high and ready is low.
//   wr_en/wr_addr/wr_data    : imem write port, one strobe per packed word
//   cpu_hold/done/error      : core hold and load status
// Modports: master = loader side, slave = stream source / memory / core side.
// -----------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int Width     = 32,
   parameter int AddrWidth = 32
);
   logic                 start;
   logic                 in_valid;
   logic [7:0]           in_data;
   logic                 in_ready;
   logic                 wr_en;
   logic [AddrWidth-1:0] wr_addr;
   logic [Width-1:0]     wr_data;
   logic                 cpu_hold;
   logic                 done;
   logic                 error;

   modport master (
      input  start, in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
   );

   modport slave (
      output start, in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_packer
// Assembles accepted stream bytes little-endian (first byte -> [7:0]).
//   clk, reset   : clock, asynchronous active-low reset
//   clear        : drop any partial word and restart at byte 0
//   in_fire      : a byte is accepted this cycle
//   in_data      : the accepted byte
//   last_idx     : index of the final byte of the current unit (count or word)
//   word_o       : packed value including the byte on in_data this cycle
//   word_ready_o : pulses with in_fire on the final byte of a unit
// Width must be at least 32 so the word-count header fits.
// -----------------------------------------------------------------------------
module imem_loader_byte_packer
   import imem_loader_pkg::*;
#(
   parameter int Width = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  in_fire,
   input  logic [7:0]            in_data,
   input  logic [PACK_CNT_W-1:0] last_idx,
   output logic [Width-1:0]      word_o,
   output logic                  word_ready_o
);

   logic [Width-1:0]      buf_q, buf_d;
   logic [PACK_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // Merge the incoming byte so the full word is visible on the final byte.
      word_o = buf_q;
      word_o[{cnt_q, 3'b000} +: 8] = in_data;
      word_ready_o = in_fire && (cnt_q == last_idx);

      buf_d = buf_q;
      cnt_d = cnt_q;
      if (clear) begin
         buf_d = '0;
         cnt_d = '0;
      end else if (in_fire) begin
         if (word_ready_o) begin
            buf_d = '0;
            cnt_d = '0;
         end else begin
            buf_d = word_o;
            cnt_d = cnt_q + PACK_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a program image as a byte stream (4-byte LE word count N, then N
// LE words), writes each word to instruction memory at BaseAddr + 4*index and
// holds the core until the image is complete.
//   clk       : clock, all state on the rising edge
//   reset     : asynchronous, active-low reset
//   bus       : imem_loader_if.master (start, byte stream, write port, status)
//   dbg_state : current FSM state
// Optional feature: define LOADER_CSUM_EN to expect one trailing byte equal to
// the XOR of all preceding bytes (count included); a mismatch ends in ERROR,
// words already written stay written.
// -----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                   Width     = 32,
   parameter int                   AddrWidth = 32,
   parameter logic [AddrWidth-1:0] BaseAddr  = '0,
   parameter int                   MaxWords  = 1024
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.master bus,
   output loader_state_t dbg_state
);

   localparam logic [PACK_CNT_W-1:0] COUNT_LAST = PACK_CNT_W'(LOADER_COUNT_BYTES - 1);
   localparam logic [PACK_CNT_W-1:0] WORD_LAST  = PACK_CNT_W'(Width / 8 - 1);

`ifdef LOADER_CSUM_EN
   localparam loader_state_t END_ST = LD_CSUM;
`else
   localparam loader_state_t END_ST = LD_DONE;
`endif

   loader_state_t        state_q, state_d;
   logic [31:0]          count_q, count_d;
   logic [31:0]          word_idx_q, word_idx_d;
   logic                 wr_en_q, wr_en_d;
   logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
   logic [Width-1:0]     wr_data_q, wr_data_d;
   logic                 in_ready_q, in_ready_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic                 cpu_hold_q, cpu_hold_d;
`ifdef LOADER_CSUM_EN
   logic [7:0]           csum_q, csum_d;
`endif

   logic                  fire;
   logic                  pk_clear;
   logic [PACK_CNT_W-1:0] pk_last;
   logic [Width-1:0]      pk_word;
   logic                  pk_ready;

   assign fire     = bus.in_valid & in_ready_q;
   assign pk_clear = !(state_q == LD_LEN || state_q == LD_DATA);
   assign pk_last  = (state_q == LD_LEN) ? COUNT_LAST : WORD_LAST;

   imem_loader_byte_packer #(.Width(Width)) u_packer (
      .clk          (clk),
      .reset        (reset),
      .clear        (pk_clear),
      .in_fire      (fire),
      .in_data      (bus.in_data),
      .last_idx     (pk_last),
      .word_o       (pk_word),
      .word_ready_o (pk_ready)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
`ifdef LOADER_CSUM_EN
      csum_d     = fire ? (csum_q ^ bus.in_data) : csum_q;
`endif

      case (state_q)
         LD_LEN: begin
            if (pk_ready) begin
               count_d    = pk_word[31:0];
               word_idx_d = '0;
               if (pk_word[31:0] == '0)
                  state_d = END_ST;
               else if (pk_word[31:0] > 32'(MaxWords))
                  state_d = LD_ERROR;
               else
                  state_d = LD_DATA;
            end
         end
         LD_DATA: begin
            if (pk_ready) begin
               wr_en_d    = 1'b1;
               wr_addr_d  = BaseAddr + (AddrWidth'(word_idx_q) << 2);
               wr_data_d  = pk_word;
               word_idx_d = word_idx_q + 32'd1;
               if (word_idx_d == count_q)
                  state_d = END_ST;
            end
         end
`ifdef LOADER_CSUM_EN
         LD_CSUM: begin
            if (fire)
               state_d = (bus.in_data == csum_q) ? LD_DONE : LD_ERROR;
         end
`endif
         LD_DONE, LD_ERROR: begin
            if (bus.start) begin
               state_d    = LD_LEN;
               count_d    = '0;
               word_idx_d = '0;
`ifdef LOADER_CSUM_EN
               csum_d     = '0;
`endif
            end
         end
         default: state_d = LD_ERROR;
      endcase

      // Status follows the next state so in_ready drops on the edge that ends
      // the stream. done waits until the final write strobe has gone, so the
      // core is never released in the same cycle as the last imem write.
      in_ready_d = is_loading(state_d);
      done_d     = (state_d == LD_DONE) && !wr_en_d;
      error_d    = (state_d == LD_ERROR);
      cpu_hold_d = !done_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= LD_LEN;
         count_q    <= '0;
         word_idx_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= BaseAddr;
         wr_data_q  <= '0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         cpu_hold_q <= 1'b1;
`ifdef LOADER_CSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         in_ready_q <= in_ready_d;
         done_q     <= done_d;
         error_q    <= error_d;
         cpu_hold_q <= cpu_hold_d;
`ifdef LOADER_CSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.cpu_hold = cpu_hold_q;
   assign bus.done     = done_q;
   assign bus.error    = error_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: byte-stream driver tasks, a write
// scoreboard fed when image words are driven and drained when wr_en fires,
// status checks for DONE/ERROR/reset, and a one-line summary.
// -----------------------------------------------------------------------------
module tb_imem_loader;
   import imem_loader_pkg::*;

   // ---------------- clock / reset ----------------
   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   loader_state_t dbg_state;

   always #5 clk = ~clk;

   imem_loader_if #(.Width(32), .AddrWidth(32)) bus ();

   imem_loader #(
      .Width     (32),
      .AddrWidth (32),
      .BaseAddr  (32'h0),
      .MaxWords  (1024)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.master),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          n_cmp  = 0;
   int          n_err  = 0;
   int          wr_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] img_q[$];
   logic [7:0]  csum_acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected word.
   always @(negedge clk) begin
      if (reset && bus.wr_en) begin
         wr_cnt++;
         check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            check("wr_addr", bus.wr_addr, exp_addr_q.pop_front());
            check("wr_data", bus.wr_data, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      t = 0;
      while (!bus.in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("byte_accepted", 32'(bus.in_ready), 32'd1);
      csum_acc = csum_acc ^ b;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_word32(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   // Sends count + img_q words (+ good checksum when enabled), pushing the
   // expected write for each word before its bytes go out.
   task automatic load_image(input int gap);
      logic [7:0] c;
      csum_acc = 8'h00;
      send_word32(32'(img_q.size()), gap);
      for (int i = 0; i < img_q.size(); i++) begin
         exp_addr_q.push_back(32'(i) * 32'd4);
         exp_q.push_back(img_q[i]);
         send_word32(img_q[i], gap);
      end
`ifdef LOADER_CSUM_EN
      c = csum_acc;
      send_byte(c, gap);
`else
      c = 8'h00;
`endif
   endtask

   task automatic wait_end(input bit want_err);
      int t;
      t = 0;
      while (!(want_err ? bus.error : bus.done) && t < 40) begin
         @(negedge clk);
         t++;
      end
      check(want_err ? "error_flag" : "done_flag",
            32'(want_err ? bus.error : bus.done), 32'd1);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({pfx, "_wr_en"},    32'(bus.wr_en),    32'd0);
      check({pfx, "_wr_addr"},  bus.wr_addr,       32'h0);
      check({pfx, "_wr_data"},  bus.wr_data,       32'h0);
      check({pfx, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
      check({pfx, "_done"},     32'(bus.done),     32'd0);
      check({pfx, "_error"},    32'(bus.error),    32'd0);
      check({pfx, "_state"},    32'(dbg_state),    32'(LD_LEN));
   endtask

   // ---------------- stimulus ----------------
   int w0;

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      csum_acc     = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      reset = 1'b1;

      // Single-word image.
      img_q = {32'h00A00513};
      w0 = wr_cnt;
      load_image(0);
      wait_end(1'b0);
      check("t1_cpu_hold", 32'(bus.cpu_hold), 32'd0);
      check("t1_wr_count", 32'(wr_cnt - w0), 32'd1);

      // Bytes offered in DONE are refused.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      repeat (4) begin
         @(negedge clk);
         check("done_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      check("done_state_kept", 32'(dbg_state), 32'(LD_DONE));
      pulse_start();
      check("rearm_done",     32'(bus.done),     32'd0);
      check("rearm_cpu_hold", 32'(bus.cpu_hold), 32'd1);
      check("rearm_in_ready", 32'(bus.in_ready), 32'd1);
      img_q = {32'hDEADBEEF};
      load_image(0);
      wait_end(1'b0);

      // Three words with a one-cycle gap before every byte.
      pulse_start();
      img_q = {32'h11223344, 32'h55667788, 32'h99AABBCC};
      w0 = wr_cnt;
      load_image(1);
      wait_end(1'b0);
      check("t2_wr_count", 32'(wr_cnt - w0), 32'd3);

      // Empty image.
      pulse_start();
      img_q.delete();
      w0 = wr_cnt;
      load_image(0);
      wait_end(1'b0);
      check("t3_zero_wr_count", 32'(wr_cnt - w0), 32'd0);

      // Count above MaxWords.
      pulse_start();
      w0 = wr_cnt;
      send_word32(32'd1025, 0);
      wait_end(1'b1);
      @(negedge clk);
      check("err_in_ready", 32'(bus.in_ready), 32'd0);
      check("err_cpu_hold", 32'(bus.cpu_hold), 32'd1);
      check("err_done",     32'(bus.done),     32'd0);
      check("err_wr_count", 32'(wr_cnt - w0),  32'd0);
      pulse_start();
      check("err_clear",    32'(bus.error),    32'd0);
      check("err_rearm_hold", 32'(bus.cpu_hold), 32'd1);
      check("err_rearm_state", 32'(dbg_state), 32'(LD_LEN));

`ifdef LOADER_CSUM_EN
      // Wrong checksum: word is still written, then ERROR.
      w0 = wr_cnt;
      csum_acc = 8'h00;
      send_word32(32'd1, 0);
      exp_addr_q.push_back(32'h0);
      exp_q.push_back(32'h00A00513);
      send_word32(32'h00A00513, 0);
      check("csum_expected_b7", 32'(csum_acc), 32'hB7);
      send_byte(8'h00, 0);
      wait_end(1'b1);
      check("csum_bad_wr_count", 32'(wr_cnt - w0), 32'd1);
      pulse_start();
`endif

      // Reset in the middle of the first data word.
      w0 = wr_cnt;
      csum_acc = 8'h00;
      send_word32(32'd1, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_reset_values("midrst");
      repeat (2) @(negedge clk);
      check("midrst_wr_count", 32'(wr_cnt - w0), 32'd0);
      reset = 1'b1;
      img_q = {32'hCAFEBABE};
      load_image(0);
      wait_end(1'b0);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
